// File: rtl/rv32m_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states
// and the operand-signedness decode that decode logic also reuses.
package rv32m_mdu_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_t;

  function automatic logic a_signed(input logic [2:0] f3);
    return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);
  endfunction

endpackage

// File: rtl/rv32m_mdu_if.sv
// Execute-stage request / register-file write-back bundle for the multiply/divide unit.
interface rv32m_mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            flush;
  logic            busy;
  logic            done;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_addr, flush,
    input  busy, done, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_addr, flush,
    output busy, done, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/rv32m_mdu.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand magnitudes,
// sharing one XLEN+1 adder/subtractor, one bit per cycle, sign fixed up on the last step.
module rv32m_mdu
  import rv32m_mdu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  rv32m_mdu_if.slave bus
);

  state_t            state, nxt_state;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   hi, lo, b_q, res_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt;

  logic              sa, sb, div0, ovf, special, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b, spec_res;

  logic              sub, div_ok;
  logic [XLEN:0]     add_x, add_y, mul_sum;
  logic [XLEN+1:0]   add_s;
  logic [XLEN-1:0]   nxt_hi, nxt_lo, div_val, fin;
  logic [2*XLEN-1:0] prod;
  logic              last;

  // Accept-time decode: magnitudes, result sign and the early-out cases
  always_comb begin
    sa       = a_signed(bus.funct3) && bus.rs1_val[XLEN-1];
    sb       = b_signed(bus.funct3) && bus.rs2_val[XLEN-1];
    mag_a    = sa ? -bus.rs1_val : bus.rs1_val;
    mag_b    = sb ? -bus.rs2_val : bus.rs2_val;
    div0     = bus.funct3[2] && (bus.rs2_val == '0);
    ovf      = (bus.funct3 == F3_DIV || bus.funct3 == F3_REM) &&
               (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
    special  = div0 || ovf;
    spec_res = bus.funct3[1] ? (div0 ? bus.rs1_val : '0)
                             : (div0 ? '1 : bus.rs1_val);
    neg_in   = (bus.funct3[2] && bus.funct3[1]) ? sa : (sa ^ sb);
  end

  // Shared adder: MUL adds the multiplicand into hi; DIV trial-subtracts the divisor
  // from the shifted partial remainder, carry-out meaning no borrow.
  always_comb begin
    sub     = (state == S_DIV);
    add_x   = sub ? {hi, lo[XLEN-1]} : {1'b0, hi};
    add_y   = {1'b0, b_q};
    add_s   = {1'b0, add_x} + {1'b0, (sub ? ~add_y : add_y)} + {{(XLEN+1){1'b0}}, sub};
    div_ok  = add_s[XLEN+1];
    mul_sum = lo[0] ? add_s[XLEN:0] : {1'b0, hi};
    if (sub) begin
      nxt_hi = div_ok ? add_s[XLEN-1:0] : add_x[XLEN-1:0];
      nxt_lo = {lo[XLEN-2:0], div_ok};
    end else begin
      {nxt_hi, nxt_lo} = {mul_sum, lo[XLEN-1:1]};
    end
    prod = {nxt_hi, nxt_lo};
    if (neg_q) prod = -prod;
    div_val = f3_q[1] ? nxt_hi : nxt_lo;
    if (neg_q) div_val = -div_val;
    fin  = sub ? div_val : ((f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    last = (cnt == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      f3_q  <= '0;
      rd_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      res_q <= '0;
      neg_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      case (state)
        S_IDLE: if (bus.start && !bus.flush) begin
          f3_q  <= bus.funct3;
          rd_q  <= bus.rd_addr;
          hi    <= '0;
          lo    <= mag_a;
          b_q   <= mag_b;
          neg_q <= neg_in;
          cnt   <= '0;
          if (special) res_q <= spec_res;
        end
        S_MUL, S_DIV: if (!bus.flush) begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + 1'b1;
          if (last) res_q <= fin;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:
        if (bus.start && !bus.flush)
          nxt_state = special ? S_DONE : (bus.funct3[2] ? S_DIV : S_MUL);
      S_MUL, S_DIV:
        if (bus.flush)  nxt_state = S_IDLE;
        else if (last)  nxt_state = S_DONE;
      S_DONE:           nxt_state = S_IDLE;
      default:          nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != S_IDLE);
    bus.done  = (state == S_DONE) && !bus.flush;
    bus.rf_we = bus.done && (rd_q != '0);
    bus.rf_wa = bus.done ? rd_q : '0;
    bus.rf_wd = bus.done ? res_q : '0;
  end

endmodule

// File: tb/tb_rv32m_mdu.sv
// Directed bench for rv32m_mdu: issued ops push expected write-backs into a queue,
// a negedge monitor pops and checks them whenever done is seen.
module tb_rv32m_mdu;
  import rv32m_mdu_pkg::*;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned n_done = 0;
  exp_t sb[$];

  rv32m_mdu_if #(.XLEN(XLEN)) bus();

  rv32m_mdu #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Cycle numbering: the period after posedge k is cycle k+1.
  always @(negedge clk) begin
    if (rstn && bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rf_wd", bus.rf_wd, e.wd);
        check("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
        check("rf_wa", {27'd0, bus.rf_wa}, {27'd0, e.wa});
        check("done_cycle", cyc + 1, e.due);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit special,
                       input bit track);
    exp_t e;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_addr = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (track) begin
      e.we  = (rd != 5'd0);
      e.wa  = rd;
      e.wd  = exp;
      e.due = cyc + (special ? 1 : XLEN + 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned k = 0;
    @(negedge clk);
    while (bus.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rd, input logic [31:0] exp, input bit special);
    issue(f3, a, b, rd, exp, special, 1'b1);
    wait_idle(60);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    int unsigned d0;
    bus.start = 1'b0; bus.funct3 = '0; bus.rs1_val = '0; bus.rs2_val = '0;
    bus.rd_addr = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_done",  {31'd0, bus.done},  32'd0);
    check("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("rst_rf_wa", {27'd0, bus.rf_wa}, 32'd0);
    check("rst_rf_wd", bus.rf_wd,          32'd0);
    rstn = 1'b1;

    op(F3_MUL,    32'd7,        32'd6,        5'd5,  32'h0000002A, 1'b0);
    op(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000, 1'b0);
    op(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b0);
    op(F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 1'b0);
    op(F3_MUL,    32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFF1, 1'b0);
    op(F3_MULHU,  32'h80000000, 32'd2,        5'd6,  32'h00000001, 1'b0);
    op(F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 1'b0);
    op(F3_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0);
    op(F3_DIVU,   32'd100,      32'd7,        5'd9,  32'd14,       1'b0);
    op(F3_REMU,   32'd100,      32'd7,        5'd10, 32'd2,        1'b0);
    op(F3_DIV,    32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1'b1);
    op(F3_REM,    32'd5,        32'd0,        5'd12, 32'd5,        1'b1);
    op(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b1);
    op(F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1'b1);
    op(F3_DIVU,   32'd9,        32'd0,        5'd15, 32'hFFFFFFFF, 1'b1);
    op(F3_REMU,   32'd9,        32'd0,        5'd16, 32'd9,        1'b1);

    // rd=0 suppresses the write; a start pulse while busy must be ignored
    d0 = n_done;
    issue(F3_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F3_MUL; bus.rs1_val = 32'd9; bus.rs2_val = 32'd9;
    bus.rd_addr = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(60);
    repeat (3) @(negedge clk);
    check("single_done", n_done - d0, 32'd1);

    // Asynchronous reset in the middle of an operation
    d0 = n_done;
    issue(F3_MUL, 32'd11, 32'd13, 5'd21, 32'd143, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("midrst_busy",  {31'd0, bus.busy},  32'd0);
    check("midrst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_done", n_done - d0, 32'd0);

    // Flush during iteration, then a fresh op must still compute correctly
    issue(F3_DIVU, 32'd1000, 32'd3, 5'd22, 32'd333, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_done", n_done - d0, 32'd0);

    // flush and start together in IDLE: start dropped
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = F3_MUL;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", {31'd0, bus.busy}, 32'd0);

    op(F3_MUL, 32'd123, 32'd456, 5'd23, 32'd56088, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
